// File: rtl/lbp_image_host.sv
// ============================================================================
// lbp_image_host: memory-side responder for the LBP engine image interface.
// Holds the gray image, serves pixel reads, captures results, tracks status.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lbp_image_host #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic          ld_done,
  input  logic          restart,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic          gray_ready,
  output logic [7:0]    gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [7:0]    lbp_data,
  input  logic          finish,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          done,
  output logic [AW:0]   wr_count,
  output logic          err_border,
  output logic          err_proto
);

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = AW - CW;
  localparam int DEPTH = IMG_W * IMG_H;
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0] img [DEPTH];
  logic [7:0] res [DEPTH];

  logic          in_idle;
  logic          in_serve;
  logic          in_done;
  logic          load_we;
  logic          res_we;
  logic          proto_viol;
  logic          clear_status;
  logic          border_hit;
  logic [RW-1:0] lbp_row;
  logic [CW-1:0] lbp_col;

  assign in_idle  = (state == S_IDLE);
  assign in_serve = (state == S_SERVE);
  assign in_done  = (state == S_DONE);

  // Memory writes are suppressed while reset is asserted so a reset cycle
  // never leaves a stray write behind.
  assign load_we      = reset && in_idle && ld_valid;
  assign res_we       = reset && in_serve && lbp_valid;
  assign clear_status = in_done && restart;

  assign proto_viol = ((lbp_valid || gray_req) && !in_serve) ||
                      ((ld_valid || ld_done) && !in_idle);

  assign lbp_row    = lbp_addr[AW-1:CW];
  assign lbp_col    = lbp_addr[CW-1:0];
  assign border_hit = (lbp_row == '0) || (lbp_row == ROW_LAST) ||
                      (lbp_col == '0) || (lbp_col == COL_LAST);

  assign gray_data = (in_serve && gray_req) ? img[gray_addr] : 8'h00;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    gray_ready = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (ld_done) state_next = S_SERVE;
      end
      S_SERVE: begin
        gray_ready = 1'b1;
        if (finish) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (restart) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_we) img[ld_addr] <= ld_data;
  end

  // Read and write share the edge, so a same-address read returns old data.
  always_ff @(posedge clk) begin
    if (res_we) res[lbp_addr] <= lbp_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= res[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_count   <= '0;
      err_border <= 1'b0;
      err_proto  <= 1'b0;
    end else if (clear_status) begin
      wr_count   <= '0;
      err_border <= 1'b0;
      err_proto  <= 1'b0;
    end else begin
      if (res_we) begin
        if (wr_count != '1) wr_count <= wr_count + (AW + 1)'(1);
        if (border_hit) err_border <= 1'b1;
      end
      if (proto_viol) err_proto <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lbp_image_host.sv
// ============================================================================
// tb_lbp_image_host: directed bench with an array-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lbp_image_host;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;
  localparam int DEPTH = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_data = '0;
  logic          ld_done = 1'b0;
  logic          restart = 1'b0;
  logic          gray_req = 1'b0;
  logic [AW-1:0] gray_addr = '0;
  logic          gray_ready;
  logic [7:0]    gray_data;
  logic          lbp_valid = 1'b0;
  logic [AW-1:0] lbp_addr = '0;
  logic [7:0]    lbp_data = '0;
  logic          finish = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          done;
  logic [AW:0]   wr_count;
  logic          err_border;
  logic          err_proto;

  lbp_image_host #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .restart(restart),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_ready(gray_ready), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
    .rd_addr(rd_addr), .rd_data(rd_data), .done(done), .wr_count(wr_count),
    .err_border(err_border), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = idle, 1 = serving, 2 = done.
  int       m_state = 0;
  int       m_cnt = 0;
  bit       m_eb = 0;
  bit       m_ep = 0;
  int       m_rd = 0;
  bit       m_rd_known = 0;
  bit       checking = 0;
  bit [7:0] img_m [DEPTH];
  bit [7:0] res_m [DEPTH];
  bit       res_known [DEPTH];

  always @(posedge clk) begin
    if (!reset) begin
      m_state = 0; m_cnt = 0; m_eb = 0; m_ep = 0; m_rd = 0; m_rd_known = 1;
    end else begin
      int row, col;
      m_rd       = res_m[rd_addr];
      m_rd_known = res_known[rd_addr];
      if (((lbp_valid || gray_req) && m_state != 1) ||
          ((ld_valid || ld_done) && m_state != 0))
        m_ep = 1;
      case (m_state)
        0: begin
          if (ld_valid) img_m[ld_addr] = ld_data;
          if (ld_done) m_state = 1;
        end
        1: begin
          if (lbp_valid) begin
            res_m[lbp_addr] = lbp_data;
            res_known[lbp_addr] = 1;
            if (m_cnt < (1 << (AW + 1)) - 1) m_cnt++;
            row = int'(lbp_addr) / IMG_W;
            col = int'(lbp_addr) % IMG_W;
            if (row == 0 || row == IMG_H - 1 || col == 0 || col == IMG_W - 1) m_eb = 1;
          end
          if (finish) m_state = 2;
        end
        default: begin
          if (restart) begin
            m_state = 0; m_cnt = 0; m_eb = 0; m_ep = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("gray_ready", int'(gray_ready), (m_state == 1) ? 1 : 0);
      chk("gray_data", int'(gray_data),
          (m_state == 1 && gray_req) ? int'(img_m[gray_addr]) : 0);
      chk("done", int'(done), (m_state == 2) ? 1 : 0);
      chk("wr_count", int'(wr_count), m_cnt);
      chk("err_border", int'(err_border), int'(m_eb));
      chk("err_proto", int'(err_proto), int'(m_ep));
      if (m_rd_known) chk("rd_data", int'(rd_data), m_rd);
    end
  end

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] a;
    do_reset();
    checking = 1;
    @(negedge clk);
    chk("lit_reset_ready", int'(gray_ready), 0);
    chk("lit_reset_done", int'(done), 0);
    chk("lit_reset_cnt", int'(wr_count), 0);
    chk("lit_reset_rd", int'(rd_data), 0);
    chk("lit_reset_errp", int'(err_proto), 0);

    // Read request while idle
    step();
    gray_req = 1'b1; gray_addr = 14'h0181;
    @(negedge clk);
    chk("lit_idle_gray_data", int'(gray_data), 0);
    step();
    gray_req = 1'b0;
    @(negedge clk);
    chk("lit_idle_err_proto", int'(err_proto), 1);

    do_reset();

    // Load the whole image; the final load coincides with ld_done
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1;
      ld_addr  = AW'(i);
      a        = AW'(i);
      ld_data  = a[7:0];
      ld_done  = (i == DEPTH - 1);
      step();
    end
    ld_valid = 1'b0; ld_done = 1'b0;
    @(negedge clk);
    chk("lit_ready_after_load", int'(gray_ready), 1);
    gray_req = 1'b1; gray_addr = 14'h0181;
    @(negedge clk);
    chk("lit_gray_0181", int'(gray_data), 8'h81);
    step();
    gray_addr = AW'(DEPTH - 1);
    @(negedge clk);
    chk("lit_gray_last", int'(gray_data), 8'hFF);
    step();
    gray_req = 1'b0;

    // Interior write plus a restart pulse that must be ignored
    lbp_valid = 1'b1; lbp_addr = 14'd129; lbp_data = 8'hA5; restart = 1'b1;
    step();
    lbp_valid = 1'b0; restart = 1'b0; rd_addr = 14'd129;
    @(negedge clk);
    chk("lit_cnt_1", int'(wr_count), 1);
    chk("lit_border_0", int'(err_border), 0);
    chk("lit_restart_no_err", int'(err_proto), 0);
    step();
    @(negedge clk);
    chk("lit_rd_129", int'(rd_data), 8'hA5);

    // Same-address read during write returns the old value
    lbp_valid = 1'b1; lbp_data = 8'h5A;
    step();
    lbp_valid = 1'b0;
    @(negedge clk);
    chk("lit_rbw_old", int'(rd_data), 8'hA5);
    step();
    @(negedge clk);
    chk("lit_rbw_new", int'(rd_data), 8'h5A);

    // Border writes: top-left, bottom row, right column
    lbp_valid = 1'b1; lbp_addr = 14'd0; lbp_data = 8'h3C;
    step();
    lbp_valid = 1'b0; rd_addr = 14'd0;
    @(negedge clk);
    chk("lit_border_1", int'(err_border), 1);
    chk("lit_cnt_3", int'(wr_count), 3);
    step();
    @(negedge clk);
    chk("lit_rd_0", int'(rd_data), 8'h3C);
    lbp_valid = 1'b1; lbp_addr = AW'(127 * 128 + 5); lbp_data = 8'h11;
    step();
    lbp_addr = AW'(3 * 128 + 127); lbp_data = 8'h22;
    step();
    lbp_addr = AW'(64 * 128 + 64); lbp_data = 8'h33; rd_addr = AW'(127 * 128 + 5);
    step();

    // Write coinciding with finish, plus an ld_valid outside idle
    lbp_addr = 14'd200; lbp_data = 8'h77; finish = 1'b1; ld_valid = 1'b1;
    step();
    lbp_valid = 1'b0; ld_valid = 1'b0; rd_addr = 14'd200;
    @(negedge clk);
    chk("lit_done_1", int'(done), 1);
    chk("lit_ready_0", int'(gray_ready), 0);
    chk("lit_cnt_7", int'(wr_count), 7);
    step();
    finish = 1'b0;
    @(negedge clk);
    chk("lit_rd_200", int'(rd_data), 8'h77);
    lbp_valid = 1'b1; lbp_addr = 14'd300; lbp_data = 8'h99;
    step();
    lbp_valid = 1'b0;
    @(negedge clk);
    chk("lit_late_write_cnt", int'(wr_count), 7);
    chk("lit_late_write_err", int'(err_proto), 1);

    // Restart, re-enter serving without reload, image retained
    restart = 1'b1;
    step();
    restart = 1'b0;
    @(negedge clk);
    chk("lit_restart_cnt", int'(wr_count), 0);
    chk("lit_restart_errs", int'(err_proto) + int'(err_border), 0);
    chk("lit_restart_done", int'(done), 0);
    ld_done = 1'b1;
    step();
    ld_done = 1'b0; gray_req = 1'b1; gray_addr = 14'h0234;
    @(negedge clk);
    chk("lit_retained_0234", int'(gray_data), 8'h34);
    step();
    gray_req = 1'b0;

    // Reset while serving
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("lit_midreset_ready", int'(gray_ready), 0);
    ld_done = 1'b1;
    step();
    ld_done = 1'b0; gray_req = 1'b1; gray_addr = 14'h00FF;
    @(negedge clk);
    chk("lit_after_reset_00ff", int'(gray_data), 8'hFF);
    step();
    gray_req = 1'b0;
    step(); step();

    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
